// File: rtl/commit_stage.sv
// commit_stage: two-slot commit register feeding a 32x32 register file.
// The write-back of the commit register is bypassed combinationally to the
// decode read ports, so results are visible one cycle after they arrive.
// Optional feature: define COMMIT_PERF_CNT_EN to add the retire_cnt counter.
module commit_stage #(
  parameter int NREAD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0][37:0]       cmt_require,  // per slot: {result[31:0], need, addr[4:0]}
  input  logic [1:0]             cmt_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [NREAD-1:0][4:0]  rd_addr,
  output logic [NREAD-1:0][31:0] rd_data,
  output logic [1:0]             wb_valid,
  output logic [1:0][4:0]        wb_addr,
  output logic [1:0][31:0]       wb_data
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [31:0]            retire_cnt
`endif
);

  // Commit register fields
  logic [1:0]       r_valid;
  logic [1:0]       r_need;
  logic [1:0][4:0]  r_addr;
  logic [1:0][31:0] r_data;

  // Register file; kept in flops because reset must clear every entry
  logic [31:0] r_rf [0:31];

  logic [1:0] w_wb_valid;

  // Commit register: reset, flush clears valids (wins over stall), stall holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_need  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (!stall) begin
      for (int s = 0; s < 2; s++) begin
        r_valid[s] <= cmt_valid[s];
        r_data[s]  <= cmt_require[s][37:6];
        r_need[s]  <= cmt_require[s][5];
        r_addr[s]  <= cmt_require[s][4:0];
      end
    end
  end

  // Write-back strobes and forwarding outputs straight from the commit register
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wb
      assign w_wb_valid[gi] = r_valid[gi] & r_need[gi] & (r_addr[gi] != 5'd0);
      assign wb_valid[gi]   = w_wb_valid[gi];
      assign wb_addr[gi]    = r_addr[gi];
      assign wb_data[gi]    = r_data[gi];
    end
  endgenerate

  // Register file write; slot 1 is written last so it wins on equal addresses.
  // Writes continue through stall/flush since the commit entries are older.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        r_rf[r] <= '0;
      end
    end else begin
      if (w_wb_valid[0]) r_rf[r_addr[0]] <= r_data[0];
      if (w_wb_valid[1]) r_rf[r_addr[1]] <= r_data[1];
    end
  end

  // Read ports with bypass from the commit register, slot 1 taking priority
  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      always_comb begin
        if (rd_addr[gi] == 5'd0) begin
          rd_data[gi] = '0;
        end else if (w_wb_valid[1] && (r_addr[1] == rd_addr[gi])) begin
          rd_data[gi] = r_data[1];
        end else if (w_wb_valid[0] && (r_addr[0] == rd_addr[gi])) begin
          rd_data[gi] = r_data[0];
        end else begin
          rd_data[gi] = r_rf[rd_addr[gi]];
        end
      end
    end
  endgenerate

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] r_retire_cnt;

  // Retired-instruction counter: adds the number of valid commit slots per unstalled edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (!stall) begin
      r_retire_cnt <= r_retire_cnt + {31'd0, r_valid[1]} + {31'd0, r_valid[0]};
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule
